controlpath_multiciclo: RTL and testbench

Multicycle MIPS32 control unit, the sequential successor of the single-cycle `controlpath` decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states. Memory accesses wait on a ready handshake guarded by a parametrised timeout. Illegal opcodes and memory timeouts are reported as faults. It drives the multicycle datapath: a shared memory, IR, A/B/ALUOut registers and PC mux.

---
 rtl/controlpath_multiciclo.sv | 264 ++++++++++++++++++++++++++
 tb/tb_controlpath_multiciclo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlpath_multiciclo.sv
// controlpath_multiciclo: multicycle MIPS32 control FSM with memory-ready timeout and sticky fault code.
// Optional feature macro CTRL_IMM_EN: decode addi/andi/ori/slti through IMMEX/IMMWB.
module controlpath_multiciclo #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] instruccion,
  input  logic [5:0] CampoFuncion,
  input  logic       zero,
  input  logic       memListo,
  output logic       EscrPC,
  output logic       IoD,
  output logic       LeerMem,
  output logic       EscrMem,
  output logic       EscrIR,
  output logic       MemaReg,
  output logic       RegDest,
  output logic       EscrReg,
  output logic       FuenteALUA,
  output logic [1:0] FuenteALUB,
  output logic [1:0] FuentePC,
  output logic [2:0] controldeALU,
  output logic [3:0] estado,
  output logic [1:0] fallo
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    RWB    = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    IMMEX  = 4'd11,
    IMMWB  = 4'd12,
    TRAP   = 4'd13
  } estadoT;

  typedef struct packed {
    logic       ioD;
    logic       leerMem;
    logic       escrMem;
    logic       memaReg;
    logic       regDest;
    logic       escrReg;
    logic       fuenteALUA;
    logic       pcJump;
    logic [1:0] fuenteALUB;
    logic [1:0] fuentePC;
    logic [2:0] alu;
  } ctrlT;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef CTRL_IMM_EN
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;
`endif

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [1:0] FalloIlegal  = 2'b01;
  localparam logic [1:0] FalloTimeout = 2'b10;

  localparam logic [7:0] TimeoutUltimo = 8'(MEM_TIMEOUT - 1);

  estadoT     estadoQ, estadoSig;
  logic [7:0] cuentaQ, cuentaSig;
  logic [1:0] falloQ, falloSig;
  ctrlT       ctrlQ;
  logic [2:0] immAlu;

  function automatic logic functValid(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: functValid = 1'b1;
      default:                                                functValid = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] aluFromFunct(input logic [5:0] f);
    case (f)
      6'b100010: aluFromFunct = AluSub;
      6'b100100: aluFromFunct = AluAnd;
      6'b100101: aluFromFunct = AluOr;
      6'b101010: aluFromFunct = AluSlt;
      default:   aluFromFunct = AluAdd;
    endcase
  endfunction

`ifdef CTRL_IMM_EN
  function automatic logic [2:0] aluFromOpcode(input logic [5:0] op);
    case (op)
      OpAndi:  aluFromOpcode = AluAnd;
      OpOri:   aluFromOpcode = AluOr;
      OpSlti:  aluFromOpcode = AluSlt;
      default: aluFromOpcode = AluAdd;
    endcase
  endfunction

  assign immAlu = aluFromOpcode(instruccion);
`else
  assign immAlu = AluAdd;
`endif

  // Outputs are registered from the state being entered, so they line up with estadoQ.
  function automatic ctrlT ctrlFor(input estadoT s, input logic [5:0] f, input logic [2:0] iAlu);
    ctrlT c;
    c = '0;
    case (s)
      FETCH: begin
        c.leerMem    = 1'b1;
        c.fuenteALUB = 2'b01;
        c.alu        = AluAdd;
      end
      DECODE: begin
        c.fuenteALUB = 2'b11;
        c.alu        = AluAdd;
      end
      MEMADR: begin
        c.fuenteALUA = 1'b1;
        c.fuenteALUB = 2'b10;
        c.alu        = AluAdd;
      end
      MEMRD: begin
        c.leerMem = 1'b1;
        c.ioD     = 1'b1;
      end
      MEMWB: begin
        c.escrReg = 1'b1;
        c.memaReg = 1'b1;
      end
      MEMWR: begin
        c.escrMem = 1'b1;
        c.ioD     = 1'b1;
      end
      EXEC: begin
        c.fuenteALUA = 1'b1;
        c.alu        = aluFromFunct(f);
      end
      RWB: begin
        c.escrReg = 1'b1;
        c.regDest = 1'b1;
      end
      BRANCH: begin
        c.fuenteALUA = 1'b1;
        c.alu        = AluSub;
        c.fuentePC   = 2'b01;
      end
      JUMP: begin
        c.fuentePC = 2'b10;
        c.pcJump   = 1'b1;
      end
      IMMEX: begin
        c.fuenteALUA = 1'b1;
        c.fuenteALUB = 2'b10;
        c.alu        = iAlu;
      end
      IMMWB: c.escrReg = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    estadoSig = estadoQ;
    cuentaSig = cuentaQ;
    falloSig  = falloQ;
    case (estadoQ)
      IDLE: estadoSig = FETCH;
      FETCH, MEMRD, MEMWR: begin
        // A ready on the last allowed cycle still completes normally.
        if (memListo) begin
          case (estadoQ)
            FETCH:   estadoSig = DECODE;
            MEMRD:   estadoSig = MEMWB;
            default: estadoSig = FETCH;
          endcase
        end else if (cuentaQ == TimeoutUltimo) begin
          estadoSig = TRAP;
          falloSig  = FalloTimeout;
        end else begin
          cuentaSig = cuentaQ + 8'd1;
        end
      end
      DECODE: begin
        case (instruccion)
          OpRtype:     estadoSig = EXEC;
          OpLw, OpSw:  estadoSig = MEMADR;
          OpBeq:       estadoSig = BRANCH;
          OpJ:         estadoSig = JUMP;
`ifdef CTRL_IMM_EN
          OpAddi, OpAndi, OpOri, OpSlti: estadoSig = IMMEX;
`endif
          default: begin
            estadoSig = TRAP;
            falloSig  = FalloIlegal;
          end
        endcase
      end
      MEMADR: estadoSig = (instruccion == OpSw) ? MEMWR : MEMRD;
      EXEC: begin
        if (functValid(CampoFuncion)) begin
          estadoSig = RWB;
        end else begin
          estadoSig = TRAP;
          falloSig  = FalloIlegal;
        end
      end
      MEMWB, RWB, BRANCH, JUMP, IMMWB: estadoSig = FETCH;
      IMMEX: estadoSig = IMMWB;
      TRAP:  estadoSig = TRAP;
      default: estadoSig = IDLE;
    endcase
    if (estadoSig != estadoQ &&
        (estadoSig == FETCH || estadoSig == MEMRD || estadoSig == MEMWR)) begin
      cuentaSig = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estadoQ <= IDLE;
      cuentaQ <= '0;
      falloQ  <= '0;
      ctrlQ   <= '0;
    end else begin
      estadoQ <= estadoSig;
      cuentaQ <= cuentaSig;
      falloQ  <= falloSig;
      ctrlQ   <= ctrlFor(estadoSig, CampoFuncion, immAlu);
    end
  end

  assign EscrIR       = (estadoQ == FETCH) & memListo;
  assign EscrPC       = ((estadoQ == FETCH) & memListo) | ((estadoQ == BRANCH) & zero) | ctrlQ.pcJump;
  assign IoD          = ctrlQ.ioD;
  assign LeerMem      = ctrlQ.leerMem;
  assign EscrMem      = ctrlQ.escrMem;
  assign MemaReg      = ctrlQ.memaReg;
  assign RegDest      = ctrlQ.regDest;
  assign EscrReg      = ctrlQ.escrReg;
  assign FuenteALUA   = ctrlQ.fuenteALUA;
  assign FuenteALUB   = ctrlQ.fuenteALUB;
  assign FuentePC     = ctrlQ.fuentePC;
  assign controldeALU = ctrlQ.alu;
  assign estado       = estadoQ;
  assign fallo        = falloQ;

endmodule

// File: tb/tb_controlpath_multiciclo.sv
// Bench for controlpath_multiciclo: per-cycle expected outputs queued as stimulus is driven, compared mid-cycle.
module tb_controlpath_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] instruccion;
  logic [5:0] CampoFuncion;
  logic       zero;
  logic       memListo;
  logic       EscrPC, IoD, LeerMem, EscrMem, EscrIR, MemaReg, RegDest, EscrReg, FuenteALUA;
  logic [1:0] FuenteALUB, FuentePC, fallo;
  logic [2:0] controldeALU;
  logic [3:0] estado;

  typedef struct packed {
    logic       escrPC, ioD, leerMem, escrMem, escrIR, memaReg, regDest, escrReg, aluA;
    logic [1:0] aluB;
    logic [1:0] srcPC;
    logic [2:0] aluOp;
    logic [3:0] st;
    logic [1:0] flt;
  } outsT;

  outsT obs, exp;
  outsT sb[$];
  int   checks = 0;
  int   errors = 0;

  controlpath_multiciclo #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .instruccion(instruccion), .CampoFuncion(CampoFuncion),
    .zero(zero), .memListo(memListo), .EscrPC(EscrPC), .IoD(IoD), .LeerMem(LeerMem),
    .EscrMem(EscrMem), .EscrIR(EscrIR), .MemaReg(MemaReg), .RegDest(RegDest),
    .EscrReg(EscrReg), .FuenteALUA(FuenteALUA), .FuenteALUB(FuenteALUB),
    .FuentePC(FuentePC), .controldeALU(controldeALU), .estado(estado), .fallo(fallo)
  );

  always #5 clk = ~clk;

  assign obs = {EscrPC, IoD, LeerMem, EscrMem, EscrIR, MemaReg, RegDest, EscrReg, FuenteALUA,
                FuenteALUB, FuentePC, controldeALU, estado, fallo};

  function automatic outsT model(input int unsigned st, input logic ls, input logic z,
                                 input logic [2:0] op, input logic [1:0] flt);
    outsT o;
    o = '0;
    o.st = st[3:0];
    case (st)
      1:  begin o.leerMem = 1'b1; o.aluB = 2'b01; o.aluOp = 3'b010; o.escrIR = ls; o.escrPC = ls; end
      2:  begin o.aluB = 2'b11; o.aluOp = 3'b010; end
      3:  begin o.aluA = 1'b1; o.aluB = 2'b10; o.aluOp = 3'b010; end
      4:  begin o.leerMem = 1'b1; o.ioD = 1'b1; end
      5:  begin o.escrReg = 1'b1; o.memaReg = 1'b1; end
      6:  begin o.escrMem = 1'b1; o.ioD = 1'b1; end
      7:  begin o.aluA = 1'b1; o.aluOp = op; end
      8:  begin o.escrReg = 1'b1; o.regDest = 1'b1; end
      9:  begin o.aluA = 1'b1; o.aluOp = 3'b110; o.srcPC = 2'b01; o.escrPC = z; end
      10: begin o.srcPC = 2'b10; o.escrPC = 1'b1; end
      11: begin o.aluA = 1'b1; o.aluB = 2'b10; o.aluOp = op; end
      12: o.escrReg = 1'b1;
      13: o.flt = flt;
      default: ;
    endcase
    return o;
  endfunction

  // Drives one cycle's inputs and queues the outputs that cycle must show.
  task automatic stim(input logic ls, input logic z, input int unsigned st,
                      input logic [2:0] op, input logic [1:0] flt);
    memListo = ls;
    zero     = z;
    sb.push_back(model(st, ls, z, op, flt));
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; memListo = 1'b0; zero = 1'b0; instruccion = '0; CampoFuncion = '0;
    repeat (2) @(posedge clk);
    #1;
    stim(1'b1, 1'b1, 0, 3'b000, 2'b00);
    @(negedge clk); exp = sb.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_held got %h want %h", obs, exp); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stim(1'b1, 1'b0, 0, 3'b000, 2'b00);
    @(negedge clk); exp = sb.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_idle got %h want %h", obs, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [5:0]  fn[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0]  op[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    int unsigned st[4] = '{1, 2, 7, 8};
    for (int k = 0; k < 5; k++) begin
      instruccion = 6'b000000; CampoFuncion = fn[k];
      for (int i = 0; i < 4; i++) begin
        stim(1'b1, 1'b0, st[i], op[k], 2'b00);
        @(negedge clk); exp = sb.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL rtype%0d cyc%0d got %h want %h", k, i, obs, exp); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_lw_wait();
    int unsigned st[8] = '{1, 2, 3, 4, 4, 4, 4, 5};
    logic        ls[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    instruccion = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      stim(ls[i], 1'b0, st[i], 3'b000, 2'b00);
      @(negedge clk); exp = sb.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL lw cyc%0d got %h want %h", i, obs, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_fetch_wait();
    int unsigned st[6] = '{1, 1, 1, 2, 3, 6};
    logic        ls[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    instruccion = 6'b101011;
    for (int i = 0; i < 6; i++) begin
      stim(ls[i], 1'b0, st[i], 3'b000, 2'b00);
      @(negedge clk); exp = sb.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL sw cyc%0d got %h want %h", i, obs, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    int unsigned st[3] = '{1, 2, 9};
    for (int k = 0; k < 3; k++) begin
      instruccion = (k == 2) ? 6'b000010 : 6'b000100;
      st[2] = (k == 2) ? 10 : 9;
      for (int i = 0; i < 3; i++) begin
        stim(1'b1, (k == 0), st[i], 3'b000, 2'b00);
        @(negedge clk); exp = sb.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL brj%0d cyc%0d got %h want %h", k, i, obs, exp); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_immediate();
    logic [5:0]  opc[4] = '{6'b001101, 6'b001000, 6'b001100, 6'b001010};
    logic [2:0]  op[4]  = '{3'b001, 3'b010, 3'b000, 3'b111};
`ifdef CTRL_IMM_EN
    int unsigned st[4]  = '{1, 2, 11, 12};
`else
    int unsigned st[4]  = '{1, 2, 13, 13};
`endif
    for (int k = 0; k < 4; k++) begin
      instruccion = opc[k];
      for (int i = 0; i < 4; i++) begin
        stim(1'b1, 1'b0, st[i], op[k], 2'b01);
        @(negedge clk); exp = sb.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL imm%0d cyc%0d got %h want %h", k, i, obs, exp); end
        @(posedge clk); #1;
      end
`ifndef CTRL_IMM_EN
      applyReset();
`endif
    end
  endtask

  task automatic test_bad_funct();
    int unsigned st[4] = '{1, 2, 7, 13};
    instruccion = 6'b000000; CampoFuncion = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      stim(1'b1, 1'b0, st[i], 3'b000, 2'b01);
      @(negedge clk); exp = sb.pop_front(); checks++;
      if ((i == 2) ? (obs.st !== exp.st || obs.flt !== exp.flt) : (obs !== exp)) begin
        errors++; $display("FAIL badfunct cyc%0d got %h want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    applyReset();
  endtask

  task automatic test_illegal();
    int unsigned st[5] = '{1, 2, 13, 13, 13};
    logic        ls[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    instruccion = 6'b111111;
    for (int i = 0; i < 5; i++) begin
      stim(ls[i], 1'b1, st[i], 3'b000, 2'b01);
      @(negedge clk); exp = sb.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL illegal cyc%0d got %h want %h", i, obs, exp); end
      @(posedge clk); #1;
    end
    applyReset();
  endtask

  task automatic test_timeout();
    int unsigned st[6] = '{1, 1, 1, 1, 13, 13};
    instruccion = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      stim(1'b0, 1'b0, st[i], 3'b000, 2'b10);
      @(negedge clk); exp = sb.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL timeout cyc%0d got %h want %h", i, obs, exp); end
      @(posedge clk); #1;
    end
    applyReset();
  endtask

  task automatic test_reset_abort();
    int unsigned st[4] = '{1, 2, 3, 6};
    logic        ls[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    instruccion = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      stim(ls[i], 1'b0, st[i], 3'b000, 2'b00);
      @(negedge clk); exp = sb.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL abort cyc%0d got %h want %h", i, obs, exp); end
      if (i < 3) begin @(posedge clk); #1; end
    end
    #1 rst_n = 1'b0;
    stim(1'b0, 1'b0, 0, 3'b000, 2'b00);
    #1; exp = sb.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL abort_async got %h want %h", obs, exp); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int unsigned st[9] = '{1, 2, 10, 1, 2, 3, 4, 5, 1};
    logic [5:0]  oc[9] = '{6'b000010, 6'b000010, 6'b100011, 6'b100011, 6'b100011,
                           6'b100011, 6'b100011, 6'b100011, 6'b000000};
    for (int i = 0; i < 9; i++) begin
      instruccion = oc[i];
      stim(1'b1, 1'b0, st[i], 3'b000, 2'b00);
      @(negedge clk); exp = sb.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL b2b cyc%0d got %h want %h", i, obs, exp); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench did not finish");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_fetch_wait();
    test_branch_jump();
    test_immediate();
    test_bad_funct();
    test_illegal();
    test_timeout();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
